// File: rtl/alu_defs.sv
// Shared definitions for the sequential logic unit:
// opcode constants and FSM state encodings.
package alu_defs;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/logic_slice.sv
// One SLICE-bit wide bitwise operator,
// selected by the 2-bit opcode.
module logic_slice
  import alu_defs::*;
#(
  parameter int SLICE = 8
) (
  input  logic [1:0]       op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] y
);

  // Pure bitwise evaluation; no carry between bits.
  always_comb begin
    y = '0;
    unique case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOR: y = ~(a | b);
    endcase
  end

endmodule

// File: rtl/alu_logic_seq.sv
// Multi-cycle bitwise logic unit, one slice per clock.
// ALU_LOGIC_OVERLAP_EN: accept a new request on the response edge.
module alu_logic_seq
  import alu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             busy
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("SLICE must divide WIDTH");
  end

  state_t                       state;
  logic [IW-1:0]                idx;
  logic [1:0]                   op_l;
  logic [N-1:0][SLICE-1:0]      a_l;
  logic [N-1:0][SLICE-1:0]      b_l;
  logic [N-1:0][SLICE-1:0]      y_q;
  logic [SLICE-1:0]             r_s;
  logic                         accept;

  logic_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .op (op_l),
    .a  (a_l[idx]),
    .b  (b_l[idx]),
    .y  (r_s)
  );

  // Request side is open in IDLE (and on the response edge when overlapped).
`ifdef ALU_LOGIC_OVERLAP_EN
  always_comb in_ready = (state == S_IDLE) ||
                         ((state == S_DONE) && out_ready);
`else
  always_comb in_ready = (state == S_IDLE);
`endif

  always_comb accept    = in_valid && in_ready;
  always_comb out_valid = (state == S_DONE);
  always_comb busy      = (state != S_IDLE);
  always_comb y         = y_q;
  always_comb zero      = ~|y_q;

  // Control FSM, operand latch and slice-by-slice result update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      op_l  <= '0;
      a_l   <= '0;
      b_l   <= '0;
      y_q   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_l  <= op;
            a_l   <= a;
            b_l   <= b;
            y_q   <= '0;
            idx   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          y_q[idx] <= r_s;
          if (idx == LAST) begin
            idx   <= '0;
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            if (accept) begin
              op_l  <= op;
              a_l   <= a;
              b_l   <= b;
              y_q   <= '0;
              idx   <= '0;
              state <= S_RUN;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_logic_seq.sv
// Self-checking bench for alu_logic_seq with a
// behavioural reference model and randomized traffic.
module tb_alu_logic_seq;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [1:0]  op = 0;
  logic [31:0] a = 0;
  logic [31:0] b = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] y;
  logic        zero;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

`ifdef ALU_LOGIC_OVERLAP_EN
  localparam int PERIOD = 5;
`else
  localparam int PERIOD = 6;
`endif
  localparam int LAT = 4;

  alu_logic_seq #(.WIDTH(32), .SLICE(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] ref_op(input logic [1:0] o,
                                         input logic [31:0] x,
                                         input logic [31:0] z);
    case (o)
      2'd0:    return x & z;
      2'd1:    return x | z;
      2'd2:    return x ^ z;
      default: return ~(x | z);
    endcase
  endfunction

  // Issue one request, wait for the response, hold it for stall cycles.
  task automatic run_one(input logic [1:0] o, input logic [31:0] aa,
                         input logic [31:0] bb, input int stall,
                         output logic [31:0] yo, output logic zo,
                         output int lat, output bit ok);
    bit acc;
    ok = 0; lat = 0; acc = 0; yo = 'x; zo = 'x;
    op = o; a = aa; b = bb; in_valid = 1;
    out_ready = (stall == 0);
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    if (!acc) return;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) return;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
    end
    yo = y; zo = zero;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    #1;
    n_cmp++;
    if (in_ready !== 1 || out_valid !== 0 || busy !== 0 ||
        y !== 0 || zero !== 1) begin
      n_bad++;
      $display("FAIL reset rdy=%b ov=%b busy=%b y=%h z=%b exp 1 0 0 0 1",
               in_ready, out_valid, busy, y, zero);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_and;
    logic [31:0] yo; logic zo; int lat; bit ok;
    run_one(2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 0, yo, zo, lat, ok);
    n_cmp++;
    if (!ok || yo !== 32'h0F0F0000 || zo !== 0 || lat != LAT) begin
      n_bad++;
      $display("FAIL and ok=%0b y=%h z=%b lat=%0d exp y=0f0f0000 z=0 lat=%0d",
               ok, yo, zo, lat, LAT);
    end
    n_cmp++;
    if (in_ready !== 1 || out_valid !== 0 || busy !== 0) begin
      n_bad++;
      $display("FAIL and_idle rdy=%b ov=%b busy=%b exp 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_xor_zero;
    logic [31:0] yo; logic zo; int lat; bit ok;
    run_one(2'b10, 32'h12345678, 32'h12345678, 0, yo, zo, lat, ok);
    n_cmp++;
    if (!ok || yo !== 0 || zo !== 1) begin
      n_bad++;
      $display("FAIL xor_zero ok=%0b y=%h z=%b exp y=0 z=1", ok, yo, zo);
    end
    run_one(2'b11, 32'h0, 32'h0, 0, yo, zo, lat, ok);
    n_cmp++;
    if (!ok || yo !== 32'hFFFFFFFF || zo !== 0) begin
      n_bad++;
      $display("FAIL nor_ones ok=%0b y=%h z=%b exp y=ffffffff z=0",
               ok, yo, zo);
    end
  endtask

  task automatic test_backpressure;
    bit acc; bit seen; int extra;
    acc = 0; seen = 0; extra = 0;
    op = 2'b01; a = 32'h00F0_0001; b = 32'h8000_0000;
    in_valid = 1; out_ready = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = out_valid;
    end
    n_cmp++;
    if (!acc || !seen) begin
      n_bad++;
      $display("FAIL bp_timeout acc=%0b seen=%0b exp 1 1", acc, seen);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid;
      a = $urandom; b = $urandom; op = 2'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if (y !== 32'h80F00001 || out_valid !== 1 || in_ready !== 0 ||
          zero !== 0 || busy !== 1) begin
        n_bad++;
        $display("FAIL bp_hold%0d y=%h ov=%b rdy=%b z=%b exp 80f00001 1 0 0",
                 i, y, out_valid, in_ready, zero);
      end
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
    out_ready = 0;
    n_cmp++;
    if (extra != 0 || y !== 32'h80F00001) begin
      n_bad++;
      $display("FAIL bp_single extra=%0d y=%h exp 0 80f00001", extra, y);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] yo; logic zo; int lat; bit ok; int spur;
    spur = 0;
    op = 2'b01; a = 32'hDEADBEEF; b = 32'h0; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (in_ready !== 1 || out_valid !== 0 || busy !== 0 ||
        y !== 0 || zero !== 1) begin
      n_bad++;
      $display("FAIL mid_reset rdy=%b ov=%b busy=%b y=%h z=%b exp 1 0 0 0 1",
               in_ready, out_valid, busy, y, zero);
    end
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) spur++;
    end
    n_cmp++;
    if (spur != 0) begin
      n_bad++;
      $display("FAIL mid_reset_spur got=%0d exp 0", spur);
    end
    run_one(2'b10, 32'hA5A5A5A5, 32'hFFFF0000, 1, yo, zo, lat, ok);
    n_cmp++;
    if (!ok || yo !== 32'h5A5AA5A5 || lat != LAT) begin
      n_bad++;
      $display("FAIL after_reset ok=%0b y=%h lat=%0d exp 5a5aa5a5 %0d",
               ok, yo, lat, LAT);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  qo[3];
    logic [31:0] qa[3], qb[3];
    logic [31:0] got[$];
    int          t_rsp[$];
    int          k;
    bit          acc, rsp;
    logic [31:0] yv;
    for (int i = 0; i < 3; i++) begin
      qo[i] = 2'($urandom); qa[i] = $urandom; qb[i] = $urandom;
    end
    k = 0;
    op = qo[0]; a = qa[0]; b = qb[0];
    in_valid = 1; out_ready = 1;
    for (int c = 0; c < 80 && got.size() < 3; c++) begin
      acc = in_valid && in_ready;
      rsp = out_valid && out_ready;
      yv = y;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        if (k == 3) in_valid = 0;
        else begin op = qo[k]; a = qa[k]; b = qb[k]; end
      end
      if (rsp) begin got.push_back(yv); t_rsp.push_back(cyc); end
    end
    in_valid = 0; out_ready = 0;
    n_cmp++;
    if (got.size() != 3) begin
      n_bad++;
      $display("FAIL b2b_count got=%0d exp 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (got[i] !== ref_op(qo[i], qa[i], qb[i])) begin
          n_bad++;
          $display("FAIL b2b_val%0d got=%h exp %h", i, got[i],
                   ref_op(qo[i], qa[i], qb[i]));
        end
      end
      for (int i = 1; i < 3; i++) begin
        n_cmp++;
        if (t_rsp[i] - t_rsp[i-1] != PERIOD) begin
          n_bad++;
          $display("FAIL b2b_period%0d got=%0d exp %0d", i,
                   t_rsp[i] - t_rsp[i-1], PERIOD);
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    logic [1:0] o; logic [31:0] aa, bb, yo, ey; logic zo;
    int lat; bit ok;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom);
      aa = $urandom; bb = $urandom;
      if (i % 6 == 0) bb = aa;
      ey = ref_op(o, aa, bb);
      run_one(o, aa, bb, int'($urandom_range(0, 3)), yo, zo, lat, ok);
      n_cmp++;
      if (!ok || yo !== ey || zo !== (ey == 0) || lat != LAT) begin
        n_bad++;
        $display("FAIL rand%0d op=%0d ok=%0b y=%h z=%b lat=%0d exp %h %b %0d",
                 i, o, ok, yo, zo, lat, ey, (ey == 0), LAT);
      end
    end
  endtask

  initial begin
    test_reset;
    test_and;
    test_xor_zero;
    test_backpressure;
    test_reset_mid_run;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_logic_seq.md
Name: alu_logic_seq

Overview:
Multi-cycle bitwise logic unit for the ALU datapath. It accepts an operand pair and an opcode over a valid/ready request channel. It evaluates AND/OR/XOR/NOR one SLICE-bit slice per clock and returns the full result over a valid/ready response channel. It sits between the ALU operand issue stage and the result writeback collector, and it trades latency for narrow per-cycle gate logic.

Parameters:
WIDTH, 32, operand/result width in bits
SLICE, 8, bits processed per clock; must divide WIDTH; N = WIDTH/SLICE slice steps

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
op  input  2  opcode: 00 AND, 01 OR, 10 XOR, 11 NOR
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  collector accepts result
y  output  WIDTH  result
zero  output  1  y == 0
busy  output  1  a request is in flight (RUN or DONE)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, y=0, zero=1, slice index=0, latched operands/op=0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b and op, clear y to 0, set idx=0, go to RUN.
  - RUN: each edge computes slice idx, y[idx*SLICE +: SLICE] = op(a_l, b_l), then idx++. The edge that writes slice N-1 goes to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Latency:
  - out_valid rises exactly N edges after the accepting edge (4 for the defaults).
  - Non-overlapped issue period is N+2 cycles.
- Handshake rules:
  - in_ready=0 in RUN and DONE; in_valid is ignored there.
  - Request inputs are sampled only on the accepting edge; later changes to a/b/op have no effect.
  - In DONE, y, zero and out_valid are held stable until out_ready; back-pressure may last indefinitely.
  - out_valid never depends combinationally on out_ready.
- Outputs:
  - y is registered and keeps its value after the response handshake until the next accept clears it.
  - zero is a combinational reduction of the registered y.
  - busy = (state != IDLE).
- Arithmetic:
  - Pure bitwise; no carry and no sign.
  - NOR = ~(a|b) per bit.
  - The slice index wraps to 0 on entry to DONE.
- Reset mid-operation: asynchronous return to the reset values. The in-flight op is discarded and never produces out_valid.
- Illegal parameters: SLICE not dividing WIDTH is a synthesis-time error (elaboration check).

Optional Feature:
Macro ALU_LOGIC_OVERLAP_EN.
- Defined: in_ready = IDLE || (DONE && out_ready). A request accepted in the same edge as the response handshake goes directly to RUN and clears y on that edge. Back-to-back period is N+1 cycles.
- Undefined: in_ready only in IDLE; period N+2.
- Response ordering and values are identical in both builds.

Decomposition:
- Shared header/package alu_defs: opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11; FSM state encodings S_IDLE, S_RUN, S_DONE.
- One sub-module, logic_slice: combinational, parameterized SLICE-bit op(a,b) selected by op. It is instantiated once and fed by a slice mux on idx.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> immediately in_ready=1, out_valid=0, busy=0, y=0, zero=1.
- AND: a=32'hFFFF0000, b=32'h0F0F0F0F, out_ready=1 -> out_valid 4 edges after accept, y=32'h0F0F0000, zero=0, then in_ready=1 next cycle.
- XOR zero flag: a=b=32'h12345678, op=10 -> y=0, zero=1. Follow with NOR a=0, b=0 -> y=32'hFFFFFFFF, zero=0.
- Back-pressure: OR a=32'h00F0_0001, b=32'h8000_0000, hold out_ready=0 for 3 cycles in DONE while toggling in_valid and a/b -> y=32'h80F00001 stable, in_ready=0, no extra accept, single response.
- Reset mid-RUN: reset pulsed after 2 slice edges -> FSM in IDLE, y=0, no out_valid for the aborted op. The next request completes normally.
- Throughput: 3 consecutive requests with in_valid=1, out_ready=1 -> responses every 6 cycles; every 5 cycles with ALU_LOGIC_OVERLAP_EN; values and order unchanged.
